// File: rtl/axi_lite_reg_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to strobe-register-bus bridge.
package axi_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Cycles to wait for reg_ready before answering with SLVERR (legal range 2..255).
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    WR_RESP,
    RD_REQ,
    RD_WAIT,
    RD_RESP
  } bridge_state_t;

endpackage

// File: rtl/axi_lite_reg_bridge_if.sv
// AXI4-Lite channel bundle between a host (master) and the register bridge (slave).
interface axi_lite_reg_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 7,
  parameter int DATA_WIDTH     = 32
) ();

  logic [AXI_ADDR_WIDTH-1:0] s_awaddr;
  logic                      s_awvalid;
  logic                      s_awready;
  logic [DATA_WIDTH-1:0]     s_wdata;
  logic [DATA_WIDTH/8-1:0]   s_wstrb;
  logic                      s_wvalid;
  logic                      s_wready;
  logic [1:0]                s_bresp;
  logic                      s_bvalid;
  logic                      s_bready;
  logic [AXI_ADDR_WIDTH-1:0] s_araddr;
  logic                      s_arvalid;
  logic                      s_arready;
  logic [DATA_WIDTH-1:0]     s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rvalid;
  logic                      s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );

endinterface

// File: rtl/axi_lite_reg_bridge_hold.sv
// Single-entry valid/ready holding register: accepts one request and keeps it until granted.
module axi_req_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_payload,
  input  logic         i_clear,
  output logic         o_ready,
  output logic         o_held,
  output logic [W-1:0] o_payload
);

  logic         r_held;
  logic [W-1:0] r_payload;

  // Capture on handshake, release on grant; a grant only happens while held, so the two never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_held    <= 1'b0;
      r_payload <= '0;
    end else if (i_clear) begin
      r_held    <= 1'b0;
    end else if (i_valid && !r_held) begin
      r_held    <= 1'b1;
      r_payload <= i_payload;
    end
  end

  assign o_held    = r_held;
  assign o_ready   = !r_held;
  assign o_payload = r_payload;

endmodule

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave that turns host accesses into one-cycle reg_write/reg_read strobes.
module axi_lite_reg_bridge
  import axi_reg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = ADDR_WIDTH + 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  axi_lite_reg_bridge_if.slave    s_axi,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic                    reg_write,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb,
  output logic                    reg_read,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_ready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int WORD_BITS  = AXI_ADDR_WIDTH - 2;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic                             w_awHeld, w_wHeld, w_arHeld;
  logic                             w_awReady, w_wReady, w_arReady;
  logic [WORD_BITS-1:0]             w_awWord, w_arWord;
  logic [STRB_WIDTH+DATA_WIDTH-1:0] w_wPayload;
  logic                             w_grantWrite, w_grantRead;
  logic                             w_timeout, w_waitDone;
  bridge_state_t                    r_state, w_stateNext;

  logic                             r_regWrite, r_regRead, r_lastWasWrite;
  logic [ADDR_WIDTH-1:0]            r_regAddr;
  logic [DATA_WIDTH-1:0]            r_regWdata, r_rdata;
  logic [STRB_WIDTH-1:0]            r_regWstrb;
  logic [7:0]                       r_cnt;
  logic                             r_bvalid, r_rvalid;
  logic [1:0]                       r_bresp, r_rresp;

  axi_req_hold #(.W(WORD_BITS)) u_awHold (
    .clk(clk), .reset(reset),
    .i_valid(s_axi.s_awvalid), .i_payload(s_axi.s_awaddr[AXI_ADDR_WIDTH-1:2]),
    .i_clear(w_grantWrite),
    .o_ready(w_awReady), .o_held(w_awHeld), .o_payload(w_awWord)
  );

  axi_req_hold #(.W(STRB_WIDTH + DATA_WIDTH)) u_wHold (
    .clk(clk), .reset(reset),
    .i_valid(s_axi.s_wvalid), .i_payload({s_axi.s_wstrb, s_axi.s_wdata}),
    .i_clear(w_grantWrite),
    .o_ready(w_wReady), .o_held(w_wHeld), .o_payload(w_wPayload)
  );

  axi_req_hold #(.W(WORD_BITS)) u_arHold (
    .clk(clk), .reset(reset),
    .i_valid(s_axi.s_arvalid), .i_payload(s_axi.s_araddr[AXI_ADDR_WIDTH-1:2]),
    .i_clear(w_grantRead),
    .o_ready(w_arReady), .o_held(w_arHeld), .o_payload(w_arWord)
  );

  assign w_timeout  = (r_cnt == TIMEOUT_LAST);
  assign w_waitDone = reg_ready || w_timeout;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Next state and grants; reads win a tie only when the previous grant was a write.
  always_comb begin
    w_stateNext  = r_state;
    w_grantWrite = 1'b0;
    w_grantRead  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arHeld && (!(w_awHeld && w_wHeld) || r_lastWasWrite)) begin
          w_grantRead = 1'b1;
          w_stateNext = RD_REQ;
        end else if (w_awHeld && w_wHeld) begin
          w_grantWrite = 1'b1;
          w_stateNext  = WR_REQ;
        end
      end
      WR_REQ:  w_stateNext = WR_WAIT;
      RD_REQ:  w_stateNext = RD_WAIT;
      WR_WAIT: if (w_waitDone) w_stateNext = WR_RESP;
      RD_WAIT: if (w_waitDone) w_stateNext = RD_RESP;
      WR_RESP: if (s_axi.s_bready) w_stateNext = IDLE;
      RD_RESP: if (s_axi.s_rready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Registered register-bus request, wait counter and AXI responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regWrite     <= 1'b0;
      r_regRead      <= 1'b0;
      r_regAddr      <= '0;
      r_regWdata     <= '0;
      r_regWstrb     <= '0;
      r_lastWasWrite <= 1'b1;
      r_cnt          <= '0;
      r_bvalid       <= 1'b0;
      r_bresp        <= RESP_OKAY;
      r_rvalid       <= 1'b0;
      r_rresp        <= RESP_OKAY;
      r_rdata        <= '0;
    end else begin
      r_regWrite <= w_grantWrite;
      r_regRead  <= w_grantRead;
      if (w_grantWrite) begin
        r_regAddr      <= w_awWord[ADDR_WIDTH-1:0];
        r_regWdata     <= w_wPayload[DATA_WIDTH-1:0];
        r_regWstrb     <= w_wPayload[STRB_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        r_lastWasWrite <= 1'b1;
      end else if (w_grantRead) begin
        r_regAddr      <= w_arWord[ADDR_WIDTH-1:0];
        r_regWdata     <= '0;
        r_regWstrb     <= '0;
        r_lastWasWrite <= 1'b0;
      end
      if (r_state == WR_REQ || r_state == RD_REQ)
        r_cnt <= '0;
      else if ((r_state == WR_WAIT || r_state == RD_WAIT) && !w_waitDone)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == WR_WAIT && w_waitDone) begin
        r_bvalid <= 1'b1;
        r_bresp  <= reg_ready ? RESP_OKAY : RESP_SLVERR;
      end else if (r_state == WR_RESP && s_axi.s_bready) begin
        r_bvalid <= 1'b0;
      end
      if (r_state == RD_WAIT && w_waitDone) begin
        r_rvalid <= 1'b1;
        r_rresp  <= reg_ready ? RESP_OKAY : RESP_SLVERR;
        r_rdata  <= reg_ready ? reg_rdata : '0;
      end else if (r_state == RD_RESP && s_axi.s_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.s_awready = w_awReady;
  assign s_axi.s_wready  = w_wReady;
  assign s_axi.s_arready = w_arReady;
  assign s_axi.s_bvalid  = r_bvalid;
  assign s_axi.s_bresp   = r_bresp;
  assign s_axi.s_rvalid  = r_rvalid;
  assign s_axi.s_rresp   = r_rresp;
  assign s_axi.s_rdata   = r_rdata;

  assign reg_addr  = r_regAddr;
  assign reg_write = r_regWrite;
  assign reg_wdata = r_regWdata;
  assign reg_wstrb = r_regWstrb;
  assign reg_read  = r_regRead;

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Scoreboard bench for axi_lite_reg_bridge with a small register-file model attached.
module tb_axi_lite_reg_bridge;
  import axi_reg_pkg::*;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int AXW = 7;
  localparam int TO  = 16;

  typedef struct {
    logic [1:0]    resp;
    logic [DW-1:0] data;
    int            lat;
  } rsp_t;

  typedef struct {
    bit            isWrite;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
  } stb_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] reg_addr;
  logic          reg_write, reg_read, reg_ready;
  logic [DW-1:0] reg_wdata, reg_rdata;
  logic [3:0]    reg_wstrb;
  logic          readyEnable;
  logic [DW-1:0] regs [32];

  rsp_t bQ[$];
  rsp_t rQ[$];
  stb_t sQ[$];
  stb_t monS;
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   strobeCyc = 0;
  bit   prevB = 0;
  bit   prevR = 0;

  always #5 clk = ~clk;

  axi_lite_reg_bridge_if #(.AXI_ADDR_WIDTH(AXW), .DATA_WIDTH(DW)) axi ();

  axi_lite_reg_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AXW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .s_axi(axi.slave),
    .reg_addr(reg_addr), .reg_write(reg_write), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_read(reg_read), .reg_rdata(reg_rdata),
    .reg_ready(reg_ready)
  );

  // Cycle counter used to measure strobe-to-response latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model: applies byte strobes, answers one cycle after each strobe.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      regs[1]   <= 32'h12345678;
      regs[2]   <= 32'd10;
      reg_ready <= 1'b0;
      reg_rdata <= '0;
    end else begin
      reg_ready <= 1'b0;
      if (reg_write) begin
        for (int b = 0; b < 4; b++)
          if (reg_wstrb[b]) regs[reg_addr][8*b +: 8] <= reg_wdata[8*b +: 8];
        reg_ready <= readyEnable;
      end else if (reg_read) begin
        reg_rdata <= regs[reg_addr];
        reg_ready <= readyEnable;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic boundExpired(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: cycle bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expected strobes and responses whenever the DUT presents them.
  always @(negedge clk) begin
    if (reset) begin
      prevB = 0;
      prevR = 0;
    end else begin
      if (reg_write || reg_read) begin
        strobeCyc = cyc;
        checkOutput("no strobe while response pending", 64'(axi.s_bvalid | axi.s_rvalid), 64'd0);
        if (sQ.size() == 0) boundExpired("unexpected register strobe");
        else begin
          monS = sQ.pop_front();
          checkOutput("strobe is write", 64'(reg_write), 64'(monS.isWrite));
          checkOutput("strobe is read", 64'(reg_read), 64'(!monS.isWrite));
          checkOutput("reg_addr", 64'(reg_addr), 64'(monS.addr));
          checkOutput("reg_wdata", 64'(reg_wdata), 64'(monS.wdata));
          checkOutput("reg_wstrb", 64'(reg_wstrb), 64'(monS.wstrb));
        end
      end
      if (axi.s_bvalid) begin
        if (bQ.size() == 0) boundExpired("unexpected bvalid");
        else begin
          if (!prevB) checkOutput("b latency", 64'(cyc - strobeCyc), 64'(bQ[0].lat));
          checkOutput("bresp", 64'(axi.s_bresp), 64'(bQ[0].resp));
          if (axi.s_bready) void'(bQ.pop_front());
        end
      end
      if (axi.s_rvalid) begin
        if (rQ.size() == 0) boundExpired("unexpected rvalid");
        else begin
          if (!prevR) checkOutput("r latency", 64'(cyc - strobeCyc), 64'(rQ[0].lat));
          checkOutput("rresp", 64'(axi.s_rresp), 64'(rQ[0].resp));
          checkOutput("rdata", 64'(axi.s_rdata), 64'(rQ[0].data));
          if (axi.s_rready) void'(rQ.pop_front());
        end
      end
      prevB = axi.s_bvalid;
      prevR = axi.s_rvalid;
    end
  end

  task automatic pushStrobe(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    stb_t e;
    e.isWrite = w; e.addr = a; e.wdata = d; e.wstrb = s;
    sQ.push_back(e);
  endtask

  task automatic pushB(input logic [1:0] resp, input int lat);
    rsp_t e;
    e.resp = resp; e.data = '0; e.lat = lat;
    bQ.push_back(e);
  endtask

  task automatic pushR(input logic [1:0] resp, input logic [DW-1:0] d, input int lat);
    rsp_t e;
    e.resp = resp; e.data = d; e.lat = lat;
    rQ.push_back(e);
  endtask

  task automatic driveAw(input logic [AXW-1:0] a);
    bit got = 0;
    axi.s_awaddr = a; axi.s_awvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (axi.s_awready) begin got = 1; break; end
    end
    if (got) begin @(posedge clk); #1; end
    else boundExpired("aw handshake");
    axi.s_awvalid = 1'b0;
  endtask

  task automatic driveW(input logic [DW-1:0] d, input logic [3:0] s);
    bit got = 0;
    axi.s_wdata = d; axi.s_wstrb = s; axi.s_wvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (axi.s_wready) begin got = 1; break; end
    end
    if (got) begin @(posedge clk); #1; end
    else boundExpired("w handshake");
    axi.s_wvalid = 1'b0;
  endtask

  task automatic driveAr(input logic [AXW-1:0] a);
    bit got = 0;
    axi.s_araddr = a; axi.s_arvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (axi.s_arready) begin got = 1; break; end
    end
    if (got) begin @(posedge clk); #1; end
    else boundExpired("ar handshake");
    axi.s_arvalid = 1'b0;
  endtask

  task automatic applyStimulus(input bit isWrite, input logic [AXW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    if (isWrite) begin
      fork
        driveAw(a);
        driveW(d, s);
      join
    end else begin
      driveAr(a);
    end
  endtask

  task automatic waitIdle(input string name);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sQ.size() == 0 && bQ.size() == 0 && rQ.size() == 0) begin done = 1; break; end
    end
    if (!done) boundExpired(name);
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    reset = 1'b1; readyEnable = 1'b1;
    axi.s_awaddr = '0; axi.s_awvalid = 1'b0; axi.s_wdata = '0; axi.s_wstrb = '0;
    axi.s_wvalid = 1'b0; axi.s_araddr = '0; axi.s_arvalid = 1'b0;
    axi.s_bready = 1'b1; axi.s_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("reset awready", 64'(axi.s_awready), 64'd1);
    checkOutput("reset wready", 64'(axi.s_wready), 64'd1);
    checkOutput("reset arready", 64'(axi.s_arready), 64'd1);
    checkOutput("reset bvalid", 64'(axi.s_bvalid), 64'd0);
    checkOutput("reset rvalid", 64'(axi.s_rvalid), 64'd0);
    checkOutput("reset bresp", 64'(axi.s_bresp), 64'd0);
    checkOutput("reset rresp", 64'(axi.s_rresp), 64'd0);
    checkOutput("reset rdata", 64'(axi.s_rdata), 64'd0);
    checkOutput("reset reg_write", 64'(reg_write), 64'd0);
    checkOutput("reset reg_read", 64'(reg_read), 64'd0);
    checkOutput("reset reg_addr", 64'(reg_addr), 64'd0);
    checkOutput("reset reg_wdata", 64'(reg_wdata), 64'd0);
    checkOutput("reset reg_wstrb", 64'(reg_wstrb), 64'd0);
    @(posedge clk); #1;

    // Tie after reset: read wins, then a second AR ties again and the write wins.
    pushStrobe(0, 5'd2, '0, 4'h0);
    pushStrobe(1, 5'd0, 32'h11111111, 4'hF);
    pushStrobe(0, 5'd0, '0, 4'h0);
    pushR(RESP_OKAY, 32'd10, 2);
    pushB(RESP_OKAY, 2);
    pushR(RESP_OKAY, 32'h11111111, 2);
    fork
      driveAw(7'h00);
      driveW(32'h11111111, 4'hF);
      begin driveAr(7'h08); driveAr(7'h00); end
    join
    waitIdle("tie arbitration drain");

    // Write on an idle bridge, then read it back.
    pushStrobe(1, 5'd2, 32'hDEADBEEF, 4'hF);
    pushB(RESP_OKAY, 2);
    applyStimulus(1, 7'h08, 32'hDEADBEEF, 4'hF);
    waitIdle("idle write drain");
    pushStrobe(0, 5'd2, '0, 4'h0);
    pushR(RESP_OKAY, 32'hDEADBEEF, 2);
    applyStimulus(0, 7'h08, '0, 4'h0);
    waitIdle("readback drain");

    // Partial strobe with W arriving three cycles ahead of AW.
    pushStrobe(1, 5'd1, 32'h000000AA, 4'h1);
    pushB(RESP_OKAY, 2);
    driveW(32'h000000AA, 4'h1);
    @(negedge clk);
    checkOutput("wready low while W held", 64'(axi.s_wready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    driveAw(7'h04);
    waitIdle("partial write drain");
    pushStrobe(0, 5'd1, '0, 4'h0);
    pushR(RESP_OKAY, 32'h123456AA, 2);
    applyStimulus(0, 7'h04, '0, 4'h0);
    waitIdle("partial readback drain");

    // Back-pressure on R while a second AR waits in its holding register.
    axi.s_rready = 1'b0;
    pushStrobe(0, 5'd2, '0, 4'h0);
    pushR(RESP_OKAY, 32'hDEADBEEF, 2);
    pushStrobe(0, 5'd1, '0, 4'h0);
    pushR(RESP_OKAY, 32'h123456AA, 2);
    driveAr(7'h08);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi.s_rvalid) begin seen = 1; break; end
    end
    if (!seen) boundExpired("rvalid under back-pressure");
    @(posedge clk); #1;
    driveAr(7'h04);
    @(negedge clk);
    checkOutput("arready low while AR held", 64'(axi.s_arready), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("second read not strobed during stall", 64'(sQ.size()), 64'd1);
    axi.s_rready = 1'b1;
    waitIdle("back-pressure drain");

    // Timeout: the register file never answers.
    readyEnable = 1'b0;
    pushStrobe(0, 5'd3, '0, 4'h0);
    pushR(RESP_SLVERR, '0, TO + 1);
    applyStimulus(0, 7'h0C, '0, 4'h0);
    waitIdle("read timeout drain");
    pushStrobe(1, 5'd3, 32'hCAFEF00D, 4'hF);
    pushB(RESP_SLVERR, TO + 1);
    applyStimulus(1, 7'h0C, 32'hCAFEF00D, 4'hF);
    waitIdle("write timeout drain");

    // Reset while the write is waiting for reg_ready.
    pushStrobe(1, 5'd5, 32'h01020304, 4'hF);
    applyStimulus(1, 7'h14, 32'h01020304, 4'hF);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (reg_write) begin seen = 1; break; end
    end
    if (!seen) boundExpired("reg_write before reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    readyEnable = 1'b1;
    @(negedge clk);
    checkOutput("post-reset bvalid", 64'(axi.s_bvalid), 64'd0);
    checkOutput("post-reset awready", 64'(axi.s_awready), 64'd1);
    checkOutput("post-reset wready", 64'(axi.s_wready), 64'd1);
    checkOutput("post-reset arready", 64'(axi.s_arready), 64'd1);
    @(posedge clk); #1;
    pushStrobe(1, 5'd5, 32'h5A5A5A5A, 4'hF);
    pushB(RESP_OKAY, 2);
    applyStimulus(1, 7'h14, 32'h5A5A5A5A, 4'hF);
    waitIdle("post-reset write drain");
    pushStrobe(0, 5'd5, '0, 4'h0);
    pushR(RESP_OKAY, 32'h5A5A5A5A, 2);
    applyStimulus(0, 7'h14, '0, 4'h0);
    waitIdle("post-reset read drain");

    checkOutput("strobe queue empty", 64'(sQ.size()), 64'd0);
    checkOutput("b queue empty", 64'(bQ.size()), 64'd0);
    checkOutput("r queue empty", 64'(rQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_bridge.md
# axi_lite_reg_bridge

AXI4-Lite slave that converts host register transactions into the single-cycle strobe register bus consumed by `config_registers`. Sits directly upstream of the register file: it buffers one AW, one W and one AR request, arbitrates reads against writes, issues one-cycle `reg_write`/`reg_read` pulses, waits for `reg_ready` with a timeout, and returns B/R responses.

## Interface
- `ADDR_WIDTH`, default 5: register word-index width; matches the register file.
- `DATA_WIDTH`, default 32: data width; `DATA_WIDTH/8` strobe bits.
- `AXI_ADDR_WIDTH`, default `ADDR_WIDTH+2`: AXI byte-address width.
- `TIMEOUT_CYCLES`, default 16: maximum cycles to wait for `reg_ready`, range 2..255.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `s_awaddr` in AXI_ADDR_WIDTH; `s_awvalid` in 1; `s_awready` out 1: write address channel.
- `s_wdata` in DATA_WIDTH; `s_wstrb` in DATA_WIDTH/8; `s_wvalid` in 1; `s_wready` out 1: write data channel.
- `s_bresp` out 2; `s_bvalid` out 1; `s_bready` in 1: write response channel.
- `s_araddr` in AXI_ADDR_WIDTH; `s_arvalid` in 1; `s_arready` out 1: read address channel.
- `s_rdata` out DATA_WIDTH; `s_rresp` out 2; `s_rvalid` out 1; `s_rready` in 1: read data channel.
- `reg_addr` out ADDR_WIDTH: word index, `axaddr[ADDR_WIDTH+1:2]`. Byte-offset bits are ignored.
- `reg_write` out 1: one-cycle write pulse.
- `reg_wdata` out DATA_WIDTH; `reg_wstrb` out DATA_WIDTH/8: write data and byte mask.
- `reg_read` out 1: one-cycle read pulse.
- `reg_rdata` in DATA_WIDTH; `reg_ready` in 1: register file response.

## Operation
- **Holding registers.** There are three of them: AW (address), W (data and strobe) and AR (address). Each has a `held` flag.
  - `s_awready = !aw_held`, `s_wready = !w_held`, `s_arready = !ar_held`.
  - A request is captured on its handshake edge. Capture continues while the FSM is busy.
  - A held flag clears on the edge the request is granted.
- **FSM states:** IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- **IDLE arbitration.**
  - A write is eligible when `aw_held && w_held`. A read is eligible when `ar_held`.
  - If only one is eligible, it goes: to WR_REQ or RD_REQ.
  - If both are eligible, round-robin via a `last_was_write` flag. After reset the flag is 1, so a read wins the first tie.
  - The grant loads `reg_addr`, `reg_wdata` and `reg_wstrb` registers. A read drives `reg_wstrb = 0` and `reg_wdata = 0`.
- **WR_REQ / RD_REQ.** `reg_write` or `reg_read` is high for exactly this one cycle. The wait counter clears. The FSM then moves to WR_WAIT or RD_WAIT.
- **WR_WAIT / RD_WAIT.** `reg_addr`, `reg_wdata` and `reg_wstrb` stay stable.
  - If `reg_ready` is 1: resp = OKAY. For a read, latch `reg_rdata` into `s_rdata`. Go to the RESP state.
  - If the counter reaches `TIMEOUT_CYCLES-1` without `reg_ready`: resp = SLVERR, `s_rdata` = 0. Go to the RESP state.
  - Otherwise the counter increments.
- **WR_RESP / RD_RESP.** `s_bvalid` or `s_rvalid` is high, with data and resp held stable. On `valid && ready` the FSM returns to IDLE.
- `reg_ready` arriving outside a WAIT state is ignored.
- Reset clears all held flags, the counter, the FSM (to IDLE) and all outputs. A transaction in flight is dropped with no response.

## Timing
- Reset values:
  - `s_awready`, `s_wready`, `s_arready` = 1 in the cycle after reset, because held flags are 0.
  - `s_bvalid`, `s_rvalid`, `reg_write`, `reg_read` = 0.
  - `s_bresp`, `s_rresp` = 00.
  - `s_rdata`, `reg_addr`, `reg_wdata`, `reg_wstrb` = 0.
- **Write latency, idle bridge.** Let E0 be the later of the AW and W handshake edges.
  - `reg_write` is high between E1 and E2.
  - `reg_ready` is sampled high at E3.
  - `s_bvalid` is high from E3.
- **Read latency.** Same as write: AR handshake at E0 gives `s_rvalid` high from E3, with `s_rdata` equal to the `reg_rdata` value sampled at E3.
- All outputs are registered. There are no combinational paths from AXI inputs to AXI outputs.
- **Throughput.** At most one register transaction is outstanding. The next grant is earliest in the IDLE cycle after the response handshake.
- **Timeout.** SLVERR is presented `TIMEOUT_CYCLES` cycles after the strobe cycle.

## Structure
- Package `axi_reg_pkg` holds:
  - Response constants `RESP_OKAY = 2'b00` and `RESP_SLVERR = 2'b10`.
  - A `bridge_state_t` enum for the seven states.
  - The default `TIMEOUT_CYCLES` localparam.
- Sub-module `axi_req_hold` is a parameterised valid/ready holding register with payload width W, `held`/`ready` outputs and a `clear` input. It is instantiated three times, for AW, W and AR.

## Test plan
- **Write, idle.** AW addr 0x08 and W data 0xDEADBEEF, strb 0xF, in the same cycle → `reg_write` pulses one cycle with `reg_addr` = 2. With the register file attached, `s_bvalid` is high 3 edges later with OKAY, and a read of 0x08 returns 0xDEADBEEF.
- **Partial strobe, W before AW.** W data 0x000000AA, strb 0x1 three cycles before AW addr 0x04 → `reg_wstrb` = 0x1 and `reg_addr` = 1. A read-back of a register that held 0x12345678 gives 0x123456AA.
- **Simultaneous write and read after reset.** Write 0x00 and read 0x08 presented together → the read is granted first (`reg_read` pulse precedes `reg_write`) and returns reset value 10. The next tie is granted to the write.
- **Back-pressure.** `s_rready` held low for 5 cycles → `s_rvalid` and `s_rdata` stay stable. A new AR is accepted into holding (`s_arready` falls), but no `reg_read` is issued until the R handshake completes.
- **Timeout.** `reg_ready` tied to 0, `TIMEOUT_CYCLES` = 16, read 0x0C → `s_rresp` = SLVERR and `s_rdata` = 0, 16 cycles after the `reg_read` pulse. A write in the same setup gives `s_bresp` = SLVERR.
- **Reset mid-transaction.** `reset` asserted during WR_WAIT → next cycle: `s_bvalid` = 0, all readys = 1, FSM in IDLE. A fresh write then completes normally.
